// File: rtl/cim_pkg.sv
// Shared constants for the cascaded-integrator multiplexor.
// Frame-counter width and header word layout.
package cim_pkg;

  localparam int FCNT_W = 16;

  typedef logic [FCNT_W-1:0] fcnt_t;

  localparam fcnt_t FCNT_RESET = '0;

endpackage

// File: rtl/cim_chan_pair.sv
// One channel: ADC x cos/sin LO, scaled, then double integration (wraps modulo 2^RW).
// One register stage on the product; integrators run continuously.
module cim_chan_pair
  import cim_pkg::*;
#(
  parameter int DWI    = 16,
  parameter int LW     = 18,
  parameter int RW     = 32,
  parameter int PSHIFT = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DWI-1:0] adc,
  input  logic [LW-1:0]  lo_cos,
  input  logic [LW-1:0]  lo_sin,
  output logic [RW-1:0]  i2_cos,
  output logic [RW-1:0]  i2_sin
);

  localparam int PW = (DWI + LW > RW) ? DWI + LW : RW;

  // Operands are sign-extended to PW so the product and shift never lose sign.
  function automatic logic [RW-1:0] scale(input logic [DWI-1:0] a, input logic [LW-1:0] l);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] lx;
    logic signed [PW-1:0] pr;
    ax = {{(PW-DWI){a[DWI-1]}}, a};
    lx = {{(PW-LW){l[LW-1]}}, l};
    pr = ax * lx;
    return RW'(pr >>> PSHIFT);
  endfunction

  logic [RW-1:0] p_cos_q, p_sin_q, p_cos_d, p_sin_d;
  logic [RW-1:0] i1_cos_q, i1_sin_q, i2_cos_q, i2_sin_q;

  assign p_cos_d = scale(adc, lo_cos);
  assign p_sin_d = scale(adc, lo_sin);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_cos_q  <= '0;
      p_sin_q  <= '0;
      i1_cos_q <= '0;
      i1_sin_q <= '0;
      i2_cos_q <= '0;
      i2_sin_q <= '0;
    end else begin
      p_cos_q  <= p_cos_d;
      p_sin_q  <= p_sin_d;
      i1_cos_q <= i1_cos_q + p_cos_q;
      i1_sin_q <= i1_sin_q + p_sin_q;
      i2_cos_q <= i2_cos_q + i1_cos_q;
      i2_sin_q <= i2_sin_q + i1_sin_q;
    end
  end

  assign i2_cos = i2_cos_q;
  assign i2_sin = i2_sin_q;

endmodule

// File: rtl/cim_nchan.sv
// NCH-channel integrator bank with snapshot-on-strobe and word-serial frame readout.
// Words follow acceptance by one cycle; a strobe during readout is dropped and flagged.
module cim_nchan
  import cim_pkg::*;
#(
  parameter int NCH    = 17,
  parameter int DWI    = 16,
  parameter int LW     = 18,
  parameter int RW     = 32,
  parameter int PSHIFT = 12,
  parameter int HEADER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*DWI-1:0] adc,
  input  logic [NCH*LW-1:0]  lo_cos,
  input  logic [NCH*LW-1:0]  lo_sin,
  input  logic             sample,
  input  logic             clr_ovr,
  output logic [RW-1:0]    sr_out,
  output logic             sr_val,
  output logic             busy,
  output logic             overrun
);

  localparam int NW   = 2 * NCH;
  localparam int FLEN = NW + HEADER;
  localparam int CW   = $clog2(FLEN);
  localparam int IW   = $clog2(NW);

  logic [RW-1:0] i2_all [NW];
  logic [RW-1:0] snap_q [NW];

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    cim_chan_pair #(.DWI(DWI), .LW(LW), .RW(RW), .PSHIFT(PSHIFT)) u_pair (
      .clk    (clk),
      .rst_n  (rst_n),
      .adc    (adc[k*DWI +: DWI]),
      .lo_cos (lo_cos[k*LW +: LW]),
      .lo_sin (lo_sin[k*LW +: LW]),
      .i2_cos (i2_all[2*k]),
      .i2_sin (i2_all[2*k+1])
    );
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
  fcnt_t         frame_q, frame_d;
  fcnt_t         hdr_q;
  logic          last_word, accept, drop;

  assign last_word = busy_q && (cnt_q == CW'(FLEN - 1));
  assign accept    = sample && (!busy_q || last_word);
  assign drop      = sample && busy_q && !last_word;

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    frame_d = frame_q;
    if (accept) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      frame_d = frame_q + fcnt_t'(1);
    end else if (last_word) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q + CW'(1);
    end
    // A drop in the same cycle as a clear keeps the flag set.
    ovr_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      frame_q <= FCNT_RESET;
      hdr_q   <= FCNT_RESET;
      for (int k = 0; k < NW; k++) snap_q[k] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      frame_q <= frame_d;
      if (accept) begin
        hdr_q  <= frame_q;
        snap_q <= i2_all;
      end
    end
  end

  logic [IW-1:0] didx;
  logic [RW-1:0] word;

  always_comb begin
    didx = IW'(cnt_q - CW'(HEADER));
    word = '0;
    if (busy_q) begin
      if (HEADER != 0 && cnt_q == '0) word = RW'(hdr_q);
      else                            word = snap_q[didx];
    end
  end

  assign sr_out  = word;
  assign sr_val  = busy_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_cim_nchan.sv
// Randomised bench for cim_nchan: a cycle-level arithmetic model fills a word scoreboard,
// and a negedge monitor pops and compares every presented word.
module tb_cim_nchan;

  localparam int DWI = 16, LW = 18, RW = 32, PSHIFT = 12;
  localparam int NA = 2, NB = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sample, clr_ovr;
  logic [NA*DWI-1:0] adc_a;
  logic [NA*LW-1:0]  cos_a, sin_a;
  logic [NB*DWI-1:0] adc_b;
  logic [NB*LW-1:0]  cos_b, sin_b;
  logic [RW-1:0] out_a, out_b;
  logic val_a, val_b, busy_a, busy_b, ovr_a, ovr_b;

  cim_nchan #(.NCH(NA), .DWI(DWI), .LW(LW), .RW(RW), .PSHIFT(PSHIFT), .HEADER(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .adc(adc_a), .lo_cos(cos_a), .lo_sin(sin_a),
    .sample(sample), .clr_ovr(clr_ovr), .sr_out(out_a), .sr_val(val_a),
    .busy(busy_a), .overrun(ovr_a));

  cim_nchan #(.NCH(NB), .DWI(DWI), .LW(LW), .RW(RW), .PSHIFT(PSHIFT), .HEADER(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .adc(adc_b), .lo_cos(cos_b), .lo_sin(sin_b),
    .sample(sample), .clr_ovr(clr_ovr), .sr_out(out_b), .sr_val(val_b),
    .busy(busy_b), .overrun(ovr_b));

  int n_cmp = 0, n_bad = 0;
  int nch, hdr, flen, rem;
  bit ovr_m, sel, mon_en, rand_in;
  logic [15:0] frame_m;
  int adc_m [32], cos_m [32], sin_m [32];
  logic [31:0] i1c [32], i2c [32], pc [32], i1s [32], i2s [32], ps [32];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] prod(input int a, input int l);
    longint pr;
    pr = longint'(a) * longint'(l);
    return 32'(pr >>> PSHIFT);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fill(input int a, input int c, input int s);
    for (int k = 0; k < 32; k++) begin
      adc_m[k] = a; cos_m[k] = c; sin_m[k] = s;
    end
  endtask

  task automatic rnd();
    for (int k = 0; k < 32; k++) begin
      adc_m[k] = int'($urandom_range(0, 65535)) - 32768;
      cos_m[k] = int'($urandom_range(0, 262143)) - 131072;
      sin_m[k] = int'($urandom_range(0, 262143)) - 131072;
    end
  endtask

  task automatic pack();
    for (int k = 0; k < NA; k++) begin
      adc_a[k*DWI +: DWI] = 16'(adc_m[k]);
      cos_a[k*LW +: LW]   = 18'(cos_m[k]);
      sin_a[k*LW +: LW]   = 18'(sin_m[k]);
    end
    for (int k = 0; k < NB; k++) begin
      adc_b[k*DWI +: DWI] = 16'(adc_m[k]);
      cos_b[k*LW +: LW]   = 18'(cos_m[k]);
      sin_b[k*LW +: LW]   = 18'(sin_m[k]);
    end
  endtask

  task automatic zero_model();
    rem = 0; ovr_m = 0; frame_m = '0;
    for (int k = 0; k < 32; k++) begin
      i1c[k] = '0; i2c[k] = '0; pc[k] = '0;
      i1s[k] = '0; i2s[k] = '0; ps[k] = '0;
    end
  endtask

  // Check current state, drive inputs, then advance the model across the next rising edge.
  task automatic step(input bit smp = 1'b0, input bit clr = 1'b0, input bit rst = 1'b0);
    bit acc, drp;
    check("busy",    sel ? busy_b : busy_a, 32'(rem > 0));
    check("sr_val",  sel ? val_b  : val_a,  32'(rem > 0));
    check("overrun", sel ? ovr_b  : ovr_a,  32'(ovr_m));
    if (rand_in) rnd();
    pack();
    rst_n = !rst; sample = smp; clr_ovr = clr;
    if (rst) begin
      // The word on the bus this cycle is still shown; the rest of the frame is lost.
      while (exp_q.size() > (rem > 0 ? 1 : 0)) void'(exp_q.pop_back());
      zero_model();
    end else begin
      acc = smp && (rem <= 1);
      drp = smp && (rem > 1);
      if (acc) begin
        if (hdr != 0) exp_q.push_back({16'h0, frame_m});
        for (int k = 0; k < nch; k++) begin
          exp_q.push_back(i2c[k]);
          exp_q.push_back(i2s[k]);
        end
        frame_m = frame_m + 16'd1;
        rem = flen;
      end else if (rem > 0) begin
        rem--;
      end
      if (drp) ovr_m = 1'b1;
      else if (clr) ovr_m = 1'b0;
      for (int k = 0; k < 32; k++) begin
        i2c[k] = i2c[k] + i1c[k]; i1c[k] = i1c[k] + pc[k]; pc[k] = prod(adc_m[k], cos_m[k]);
        i2s[k] = i2s[k] + i1s[k]; i1s[k] = i1s[k] + ps[k]; ps[k] = prod(adc_m[k], sin_m[k]);
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(input int r);
    for (int i = 0; i < 400 && rem != r; i++) step();
    n_cmp++;
    if (rem != r) begin
      n_bad++;
      $display("FAIL run_until: remaining %0d expected %0d", rem, r);
    end
  endtask

  always @(negedge clk) begin
    logic v;
    logic [31:0] d;
    if (mon_en) begin
      v = sel ? val_b : val_a;
      d = sel ? out_b : out_a;
      if (v === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_word: got %h expected no word", d);
        end else begin
          check("word", d, exp_q.pop_front());
        end
      end else begin
        check("idle_out", d, 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; sample = 1'b0; clr_ovr = 1'b0;
    sel = 0; mon_en = 0; rand_in = 0;
    nch = NA; hdr = 1; flen = 2 * NA + 1;
    fill(0, 0, 0); pack(); zero_model();
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1;
    step(.rst(1)); step(.rst(1));

    // Constant mix: cos product = 100 per cycle, sin product = 0.
    fill(100, 1 << PSHIFT, 0);
    repeat (10) step();
    step(.smp(1));
    repeat (6) step();

    // Drops during readout, including drop coinciding with clear.
    rand_in = 1;
    step(.smp(1)); step();
    step(.smp(1));
    step(.smp(1), .clr(1));
    run_until(0);
    step(.clr(1)); step();
    step(.smp(1)); repeat (3) step(); step(.smp(1));
    run_until(0);
    step(.clr(1)); step();

    // Back-to-back frames via strobe on the last word.
    step(.smp(1)); run_until(1);
    step(.smp(1)); run_until(1);
    step(.smp(1)); run_until(0);
    for (int i = 0; i < 300; i++)
      step(.smp($urandom_range(0, 3) == 0), .clr($urandom_range(0, 7) == 0));
    run_until(0);

    // Full-scale negative inputs: integrators wrap many times.
    rand_in = 0;
    fill(-32768, -131072, -131072);
    for (int i = 0; i < 4096; i++) step(.smp((i % 400) == 399));
    run_until(0);

    // Reset while word 2 of a frame is on the bus.
    rand_in = 1;
    step(.smp(1)); step(); step(.smp(1));
    step(.rst(1));
    repeat (20) step();
    step(.smp(1));
    run_until(0);

    // Switch to the 17-channel, header-less instance.
    mon_en = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    sel = 1; nch = NB; hdr = 0; flen = 2 * NB;
    zero_model();
    exp_q.delete();
    mon_en = 1;
    step(.rst(1)); step(.rst(1));
    repeat (50) step();
    step(.smp(1)); repeat (10) step(); step(.smp(1));
    run_until(1);
    step(.smp(1));
    run_until(0);
    step(.clr(1)); step();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_words: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
